// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns the EX/MEM access into a req/gnt/rvalid
// bus transaction, stalls the pipeline until it completes, and extends load data.
module mem_stage_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  BusErrM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            fsm_state
);

  // Bus handshake: a request is accepted in any cycle where mem_req and mem_gnt
  // are both high; until then address, direction, data and strobes stay stable.
  // Load data is accepted only in RESP, in the cycle mem_rvalid is high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  state_t                  state, state_nxt;
  logic [CW-1:0]           to_cnt;
  logic                    acc, store, is_b, is_h, is_w, mis, issue, busy, timeout_hit;
  logic [1:0]              boff;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [DATA_WIDTH-1:0]   ld_ext, st_data;
  logic [3:0]              st_strb;

  assign acc   = MemReadM | MemWriteM;
  assign store = MemWriteM;
  assign boff  = ALUResultM[1:0];
  assign is_b  = (funct3M[1:0] == 2'b00);
  assign is_h  = (funct3M[1:0] == 2'b01);
  assign is_w  = funct3M[1];
  assign mis   = (is_h & ALUResultM[0]) | (is_w & (|ALUResultM[1:0]));
  assign issue = (state == S_IDLE) & acc & ~mis & ~rst;
  assign busy  = (state == S_REQ) | (state == S_RESP);

  // The timeout only fires when the bus does not complete in the same cycle.
  always_comb begin
    timeout_hit = 1'b0;
    if (TO_EN && busy && (to_cnt == TO_LAST)) begin
      timeout_hit = (state == S_REQ) ? ~mem_gnt : ~mem_rvalid;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (issue) state_nxt = mem_gnt ? (store ? S_DONE : S_RESP) : S_REQ;
      S_REQ: begin
        if (mem_gnt)          state_nxt = store ? S_DONE : S_RESP;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_RESP: if (mem_rvalid || timeout_hit) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      to_cnt    <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
    end else begin
      state   <= state_nxt;
      BusErrM <= timeout_hit;
      if ((state_nxt == S_REQ || state_nxt == S_RESP) && state_nxt != state) begin
        to_cnt <= '0;
      end else if (busy) begin
        to_cnt <= to_cnt + CW'(1);
      end
      if (state == S_RESP && mem_rvalid) begin
        ReadDataM <= ld_ext;
      end else if (timeout_hit) begin
        ReadDataM <= '0;
      end
    end
  end

  // Inputs are frozen by the stall, so the address offset is still valid in RESP.
  always_comb begin
    ld_byte = mem_rdata[{boff, 3'b000} +: 8];
    ld_half = ALUResultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (is_b)      ld_ext = {{24{~funct3M[2] & ld_byte[7]}}, ld_byte};
    else if (is_h) ld_ext = {{16{~funct3M[2] & ld_half[15]}}, ld_half};
    else           ld_ext = mem_rdata;
  end

  always_comb begin
    if (is_b) begin
      st_strb = 4'b0001 << boff;
      st_data = {4{WriteDataM[7:0]}};
    end else if (is_h) begin
      st_strb = ALUResultM[1] ? 4'b1100 : 4'b0011;
      st_data = {2{WriteDataM[15:0]}};
    end else begin
      st_strb = 4'b1111;
      st_data = WriteDataM;
    end
  end

  assign mem_req   = issue | ((state == S_REQ) & ~rst);
  assign StallM    = issue | (busy & ~rst);
  assign MisalignM = (state == S_IDLE) & acc & mis & ~rst;
  assign mem_we    = mem_req & store;
  assign mem_addr  = mem_req ? {ALUResultM[DATA_WIDTH-1:2], 2'b00} : '0;
  assign mem_wstrb = mem_we ? st_strb : 4'b0000;
  assign mem_wdata = mem_we ? st_data : '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: bus responder driven per access, expected load data
// queued at issue time and compared when the access completes.
module tb_mem_stage_lsu;
  localparam int W = 32;

  logic         clk, rst;
  logic         MemReadM, MemWriteM;
  logic [2:0]   funct3M;
  logic [W-1:0] ALUResultM, WriteDataM, ReadDataM;
  logic         StallM, MisalignM, BusErrM;
  logic         mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_wstrb;
  logic [1:0]   fsm_state;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rd;

  mem_stage_lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM),
    .BusErrM(BusErrM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * off));
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  // driver: one access from issue to the cycle after DONE; starts and ends at posedge+1
  task automatic run_access(input logic is_store, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int gnt_dly, input int rv_dly,
                            output int stall_cyc, output int hold_cyc, output int err_pulses,
                            output logic hold_ok, output logic done_ok);
    logic        granted;
    int          gcyc;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    granted = 1'b0; gcyc = 0; stall_cyc = 0; hold_cyc = 0; err_pulses = 0;
    hold_ok = 1'b1; done_ok = 1'b0;
    e_wdata = is_store ? ref_wdata(f3, wd) : 32'h0;
    e_wstrb = is_store ? ref_strb(f3, addr[1:0]) : 4'b0000;
    MemWriteM = is_store; MemReadM = ~is_store; funct3M = f3;
    ALUResultM = addr; WriteDataM = wd;
    for (int cyc = 0; cyc < 60; cyc++) begin
      mem_gnt    = ~granted && (cyc == gnt_dly);
      mem_rvalid = ~is_store && granted && (cyc == gcyc + 1 + rv_dly);
      mem_rdata  = mem_rvalid ? rd : $urandom;
      #1;
      if (BusErrM) err_pulses++;
      if (!StallM) begin
        done_ok = 1'b1;
        break;
      end
      stall_cyc++;
      if (mem_req) begin
        if (mem_wdata !== e_wdata || mem_wstrb !== e_wstrb || mem_we !== is_store ||
            mem_addr !== {addr[31:2], 2'b00}) hold_ok = 1'b0;
        if (!mem_gnt) hold_cyc++;
        else begin granted = 1'b1; gcyc = cyc; end
      end
      @(posedge clk); #1;
    end
    MemReadM = 1'b0; MemWriteM = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    if (BusErrM) err_pulses++;
  endtask

  task automatic test_reset();
    rst = 1'b1; MemReadM = 0; MemWriteM = 0; funct3M = 0; ALUResultM = 0; WriteDataM = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    @(posedge clk); #1;
    n_tests++; if (ReadDataM !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", ReadDataM); end
    n_tests++; if ({StallM, mem_req, MisalignM, BusErrM, mem_we} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {StallM, mem_req, MisalignM, BusErrM, mem_we}); end
    n_tests++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", fsm_state); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin n_fail++; $display("FAIL idle_outputs: got %h expected 0", {mem_addr, mem_wdata, mem_wstrb}); end
    last_rd = 32'h0;
  endtask

  task automatic test_lw_basic();
    int st, hc, ep; logic ho, dn;
    exp_q.push_back(32'hDEADBEEF);
    run_access(1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 0, 0, st, hc, ep, ho, dn);
    n_tests++; if (dn !== 1'b1) begin n_fail++; $display("FAIL lw_done: got %b expected 1", dn); end
    n_tests++; if (st != 2) begin n_fail++; $display("FAIL lw_stall: got %0d expected 2", st); end
    n_tests++; if (ho !== 1'b1) begin n_fail++; $display("FAIL lw_req_fields: got %b expected 1", ho); end
    n_tests++; if (ReadDataM !== exp_q[0]) begin n_fail++; $display("FAIL lw_data: got %h expected %h", ReadDataM, exp_q[0]); end
    last_rd = exp_q.pop_front();
  endtask

  task automatic test_load_extend();
    logic [31:0] addrs[6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h104};
    logic [2:0]  f3s[6]   = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b110};
    int st, hc, ep; logic ho, dn;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(ref_load(32'h80112233, addrs[i][1:0], f3s[i]));
      run_access(1'b0, addrs[i], f3s[i], 32'h0, 32'h80112233, i % 2, i % 3, st, hc, ep, ho, dn);
      n_tests++; if (!dn || st != (i % 2) + (i % 3) + 2) begin n_fail++; $display("FAIL ext_latency[%0d]: got done=%b stall=%0d expected stall=%0d", i, dn, st, (i % 2) + (i % 3) + 2); end
      n_tests++; if (ReadDataM !== exp_q[0]) begin n_fail++; $display("FAIL ext_data[%0d]: got %h expected %h", i, ReadDataM, exp_q[0]); end
      last_rd = exp_q.pop_front();
    end
  endtask

  task automatic test_store();
    int st, hc, ep; logic ho, dn;
    exp_q.push_back(last_rd);
    run_access(1'b1, 32'h201, 3'b000, 32'h000000A5, 32'h0, 3, 0, st, hc, ep, ho, dn);
    n_tests++; if (!dn || st != 4) begin n_fail++; $display("FAIL sb_stall: got done=%b stall=%0d expected stall=4", dn, st); end
    n_tests++; if (hc != 3 || ho !== 1'b1) begin n_fail++; $display("FAIL sb_hold: got hold=%0d ok=%b expected hold=3 ok=1", hc, ho); end
    n_tests++; if (ReadDataM !== exp_q[0]) begin n_fail++; $display("FAIL sb_rdata_kept: got %h expected %h", ReadDataM, exp_q[0]); end
    void'(exp_q.pop_front());
    exp_q.push_back(last_rd);
    run_access(1'b1, 32'h206, 3'b001, 32'h1234BEEF, 32'h0, 0, 0, st, hc, ep, ho, dn);
    n_tests++; if (!dn || st != 1 || ho !== 1'b1) begin n_fail++; $display("FAIL sh_basic: got done=%b stall=%0d ok=%b expected stall=1 ok=1", dn, st, ho); end
    n_tests++; if (ReadDataM !== exp_q[0]) begin n_fail++; $display("FAIL sh_rdata_kept: got %h expected %h", ReadDataM, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_misalign();
    logic [31:0] addrs[4] = '{32'h102, 32'h101, 32'h103, 32'h10A};
    logic [2:0]  f3s[4]   = '{3'b010, 3'b001, 3'b101, 3'b010};
    logic        wr[4]    = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(last_rd);
      MemReadM = ~wr[i]; MemWriteM = wr[i]; funct3M = f3s[i]; ALUResultM = addrs[i];
      WriteDataM = $urandom; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
      #1;
      n_tests++; if ({MisalignM, mem_req, StallM} !== 3'b100) begin n_fail++; $display("FAIL misalign[%0d]: got mis/req/stall=%b expected 100", i, {MisalignM, mem_req, StallM}); end
      @(posedge clk); #1;
      n_tests++; if (fsm_state !== 2'd0 || ReadDataM !== exp_q[0]) begin n_fail++; $display("FAIL misalign_idle[%0d]: got state=%0d rdata=%h expected state=0 rdata=%h", i, fsm_state, ReadDataM, exp_q[0]); end
      void'(exp_q.pop_front());
      MemReadM = 0; MemWriteM = 0; mem_gnt = 0; mem_rvalid = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    int st, hc, ep; logic ho, dn;
    exp_q.push_back(32'h0);
    run_access(1'b0, 32'h300, 3'b010, 32'h0, 32'h55AA55AA, 0, 1000, st, hc, ep, ho, dn);
    n_tests++; if (!dn || st != 5) begin n_fail++; $display("FAIL timeout_stall: got done=%b stall=%0d expected stall=5", dn, st); end
    n_tests++; if (ep != 1) begin n_fail++; $display("FAIL timeout_buserr: got %0d pulses expected 1", ep); end
    n_tests++; if (ReadDataM !== exp_q[0]) begin n_fail++; $display("FAIL timeout_rdata: got %h expected %h", ReadDataM, exp_q[0]); end
    n_tests++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL timeout_idle: got %0d expected 0", fsm_state); end
    last_rd = exp_q.pop_front();
  endtask

  task automatic test_back_to_back();
    int st, hc, ep, g, rv; logic ho, dn, s;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] addr, rd, wd;
    logic [2:0]  ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 10; i++) begin
      s  = 1'($urandom_range(0, 1));
      f3 = s ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      off = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) off[0] = 1'b0;
      if (f3[1]) off = 2'b00;
      addr = 32'h1000 + (32'($urandom_range(0, 255)) << 2) + 32'(off);
      rd = $urandom; wd = $urandom;
      g = $urandom_range(0, 3); rv = $urandom_range(0, 2);
      exp_q.push_back(s ? last_rd : ref_load(rd, off, f3));
      run_access(s, addr, f3, wd, rd, g, rv, st, hc, ep, ho, dn);
      n_tests++; if (!dn || st != (s ? g + 1 : g + rv + 2) || hc != g || !ho || ep != 0) begin n_fail++; $display("FAIL b2b_protocol[%0d]: got done=%b stall=%0d hold=%0d ok=%b err=%0d expected stall=%0d hold=%0d", i, dn, st, hc, ho, ep, s ? g + 1 : g + rv + 2, g); end
      n_tests++; if (ReadDataM !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, ReadDataM, exp_q[0]); end
      last_rd = exp_q.pop_front();
    end
  endtask

  task automatic test_reset_mid();
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h400;
    mem_gnt = 1'b1; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #1;
    n_tests++; if (StallM !== 1'b1 || fsm_state !== 2'd2) begin n_fail++; $display("FAIL rstmid_in_resp: got stall=%b state=%0d expected stall=1 state=2", StallM, fsm_state); end
    rst = 1'b1; MemReadM = 1'b0;
    #1;
    n_tests++; if ({mem_req, StallM} !== 2'b00 || ReadDataM !== 32'h0) begin n_fail++; $display("FAIL rstmid_async: got req/stall=%b rdata=%h expected 00 rdata=0", {mem_req, StallM}, ReadDataM); end
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    n_tests++; if (fsm_state !== 2'd0 || ReadDataM !== 32'h0 || StallM !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_rvalid: got state=%0d rdata=%h stall=%b expected state=0 rdata=0 stall=0", fsm_state, ReadDataM, StallM); end
  endtask

  initial begin
    test_reset();
    test_lw_basic();
    test_load_extend();
    test_store();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
